// File: rtl/mlp_patch_gather.sv
// mlp_patch_gather
//   For each accepted DVS event, reads the (2R+1)^2 {ts,pol} neighbourhood around (x,y) from
//   pixel memory over NPORTS lanes per beat and turns every pixel into a decayed-age feature
//   (TAU - age, clipped at the frame edges). Feature beats are buffered in a small FIFO and
//   streamed out under valid/ready. Once all beats are issued, the event is written into the
//   centre pixel.
// Ports
//   clk_i, rst_i                  clock; asynchronous active-high reset
//   ev_vld_i/ev_rdy_o             event handshake; ev_x_i, ev_y_i, ev_pol_i, ev_ts_i payload
//   mem_cen_o                     per-lane memory enable; mem_we_o write strobe (lane 0 only)
//   mem_addr_x_o, mem_addr_y_o    per-lane pixel coordinates
//   mem_wdata_o                   write word {ts,pol}; mem_rdata_i per-lane read data (1-cycle latency)
//   feat_vld_o/feat_rdy_i         feature handshake
//   feat_lane_vld_o               lane maps to a real pixel (out-of-frame pixels count, padding does not)
//   feat_age_o, feat_pol_o        per-lane feature; feat_last_o marks the event's final beat
//   busy_o                        FSM not idle; done_o one-cycle pulse on the centre write
module mlp_patch_gather #(
   parameter int unsigned DVS_WIDTH  = 346,
   parameter int unsigned DVS_HEIGHT = 260,
   parameter int unsigned XY_BITS    = 9,
   parameter int unsigned TS_BITS    = 16,
   parameter int unsigned POL_BITS   = 2,
   parameter int unsigned WORD_SIZE  = TS_BITS + POL_BITS,
   parameter int unsigned PATCH_R    = 3,
   parameter int unsigned NPORTS     = 2,
   parameter int unsigned TAU        = 64,
   parameter int unsigned FIFO_D     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          ev_vld_i,
   output logic                          ev_rdy_o,
   input  logic [XY_BITS-1:0]            ev_x_i,
   input  logic [XY_BITS-1:0]            ev_y_i,
   input  logic [POL_BITS-1:0]           ev_pol_i,
   input  logic [TS_BITS-1:0]            ev_ts_i,
   output logic [NPORTS-1:0]             mem_cen_o,
   output logic                          mem_we_o,
   output logic [NPORTS*XY_BITS-1:0]     mem_addr_x_o,
   output logic [NPORTS*XY_BITS-1:0]     mem_addr_y_o,
   output logic [WORD_SIZE-1:0]          mem_wdata_o,
   input  logic [NPORTS*WORD_SIZE-1:0]   mem_rdata_i,
   output logic                          feat_vld_o,
   input  logic                          feat_rdy_i,
   output logic [NPORTS-1:0]             feat_lane_vld_o,
   output logic [NPORTS*TS_BITS-1:0]     feat_age_o,
   output logic [NPORTS*POL_BITS-1:0]    feat_pol_o,
   output logic                          feat_last_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int unsigned PW     = 2 * PATCH_R + 1;
   localparam int unsigned NPIX   = PW * PW;
   localparam int unsigned NBEATS = (NPIX + NPORTS - 1) / NPORTS;
   localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int unsigned KW     = $clog2(NBEATS * NPORTS) + 1;
   localparam int unsigned CW     = XY_BITS + 1;
   localparam int unsigned PTRW   = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
   localparam int unsigned CNTW   = $clog2(FIFO_D + 1);
   localparam int unsigned AW     = NPORTS * TS_BITS;
   localparam int unsigned PLW    = NPORTS * POL_BITS;
   localparam int unsigned EW     = AW + PLW + NPORTS + 1;

   typedef enum logic [1:0] {StIdle, StGather, StStore} state_e;

   state_e                state_q, state_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic                  rdy_en_q;
   logic [XY_BITS-1:0]    ev_x_q, ev_y_q;
   logic [POL_BITS-1:0]   ev_pol_q;
   logic [TS_BITS-1:0]    ev_ts_q;

   logic                  accept, issue, store, room, last_beat;
   logic [CNTW:0]         occ;

   // Read stage (data returning from memory) and age stage (FIFO input)
   logic                  p1_vld_q, p1_last_q;
   logic [NPORTS-1:0]     p1_rd_q, p1_lv_q;
   logic                  p2_vld_q, p2_last_q;
   logic [NPORTS-1:0]     p2_lv_q;
   logic [AW-1:0]         p2_age_q, age_c;
   logic [PLW-1:0]        p2_pol_q, pol_c;

   logic [EW-1:0]         fifo_q [FIFO_D];
   logic [PTRW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0]       cnt_q;
   logic                  push, pop;
   logic [EW-1:0]         head;

   logic [NPORTS-1:0]         lane_pad, lane_rd;
   logic [NPORTS*XY_BITS-1:0] lane_x, lane_y;

   assign ev_rdy_o  = rdy_en_q && (state_q == StIdle);
   assign accept    = ev_vld_i && ev_rdy_o;
   assign last_beat = (beat_q == BW'(NBEATS - 1));
   assign busy_o    = (state_q != StIdle);
   assign done_o    = store;

   // Reserve FIFO space for every beat still in the read/age pipeline
   assign occ  = {1'b0, cnt_q} + (CNTW+1)'(p1_vld_q) + (CNTW+1)'(p2_vld_q);
   assign room = (occ < (CNTW+1)'(FIFO_D));

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      issue   = 1'b0;
      store   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StGather;
               beat_d  = '0;
            end
         end
         StGather: begin
            if (room) begin
               issue = 1'b1;
               if (last_beat) begin
                  state_d = StStore;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         StStore: begin
            store   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         beat_q   <= '0;
         rdy_en_q <= 1'b0;
         ev_x_q   <= '0;
         ev_y_q   <= '0;
         ev_pol_q <= '0;
         ev_ts_q  <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         rdy_en_q <= 1'b1;
         if (accept) begin
            ev_x_q   <= ev_x_i;
            ev_y_q   <= ev_y_i;
            ev_pol_q <= ev_pol_i;
            ev_ts_q  <= ev_ts_i;
         end
      end
   end

   // Per-lane geometry for the current beat and age conversion for returning data
   for (genvar l = 0; l < NPORTS; l++) begin : g_lane
      logic [KW-1:0]          k, col, row;
      logic signed [CW-1:0]   px, py;
      logic                   oof;
      logic [WORD_SIZE-1:0]   word;
      logic [TS_BITS-1:0]     d;
      logic                   hit;

      assign k   = KW'(beat_q) * KW'(NPORTS) + KW'(l);
      assign col = k % KW'(PW);
      assign row = k / KW'(PW);
      assign px  = $signed({1'b0, ev_x_q}) + $signed(CW'(col)) - $signed(CW'(PATCH_R));
      assign py  = $signed({1'b0, ev_y_q}) + $signed(CW'(row)) - $signed(CW'(PATCH_R));
      assign oof = px[CW-1] || (px >= $signed(CW'(DVS_WIDTH))) ||
                   py[CW-1] || (py >= $signed(CW'(DVS_HEIGHT)));

      assign lane_pad[l] = (k >= KW'(NPIX));
      assign lane_rd[l]  = !lane_pad[l] && !oof;
      assign lane_x[l*XY_BITS +: XY_BITS] = px[XY_BITS-1:0];
      assign lane_y[l*XY_BITS +: XY_BITS] = py[XY_BITS-1:0];

      // Word 0 marks a never-written pixel; d wraps modulo 2^TS_BITS
      assign word = mem_rdata_i[l*WORD_SIZE +: WORD_SIZE];
      assign d    = ev_ts_q - word[WORD_SIZE-1:POL_BITS];
      assign hit  = p1_rd_q[l] && (word != '0) && (d < TS_BITS'(TAU));
      assign age_c[l*TS_BITS +: TS_BITS]   = hit ? (TS_BITS'(TAU) - d) : '0;
      assign pol_c[l*POL_BITS +: POL_BITS] = hit ? word[POL_BITS-1:0] : '0;
   end

   always_comb begin
      mem_cen_o    = '0;
      mem_we_o     = 1'b0;
      mem_addr_x_o = '0;
      mem_addr_y_o = '0;
      mem_wdata_o  = '0;
      if (issue) begin
         mem_cen_o = lane_rd;
         for (int l = 0; l < NPORTS; l++) begin
            if (lane_rd[l]) begin
               mem_addr_x_o[l*XY_BITS +: XY_BITS] = lane_x[l*XY_BITS +: XY_BITS];
               mem_addr_y_o[l*XY_BITS +: XY_BITS] = lane_y[l*XY_BITS +: XY_BITS];
            end
         end
      end
      if (store) begin
         mem_cen_o[0]                = 1'b1;
         mem_we_o                    = 1'b1;
         mem_addr_x_o[XY_BITS-1:0]   = ev_x_q;
         mem_addr_y_o[XY_BITS-1:0]   = ev_y_q;
         mem_wdata_o                 = {ev_ts_q, ev_pol_q};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         p1_vld_q  <= 1'b0;
         p1_rd_q   <= '0;
         p1_lv_q   <= '0;
         p1_last_q <= 1'b0;
         p2_vld_q  <= 1'b0;
         p2_age_q  <= '0;
         p2_pol_q  <= '0;
         p2_lv_q   <= '0;
         p2_last_q <= 1'b0;
      end else begin
         p1_vld_q  <= issue;
         p1_rd_q   <= issue ? lane_rd : '0;
         p1_lv_q   <= ~lane_pad;
         p1_last_q <= last_beat;
         p2_vld_q  <= p1_vld_q;
         p2_age_q  <= age_c;
         p2_pol_q  <= pol_c;
         p2_lv_q   <= p1_lv_q;
         p2_last_q <= p1_last_q;
      end
   end

   // Output FIFO; admission control above guarantees it never overflows
   assign push = p2_vld_q;
   assign pop  = feat_vld_o && feat_rdy_i;
   assign head = fifo_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= {p2_last_q, p2_lv_q, p2_pol_q, p2_age_q};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= (wr_ptr_q == PTRW'(FIFO_D - 1)) ? '0 : wr_ptr_q + PTRW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTRW'(FIFO_D - 1)) ? '0 : rd_ptr_q + PTRW'(1);
         end
         cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
      end
   end

   assign feat_vld_o      = (cnt_q != '0);
   assign feat_age_o      = feat_vld_o ? head[AW-1:0] : '0;
   assign feat_pol_o      = feat_vld_o ? head[AW +: PLW] : '0;
   assign feat_lane_vld_o = feat_vld_o ? head[AW+PLW +: NPORTS] : '0;
   assign feat_last_o     = feat_vld_o && head[EW-1];

endmodule

// File: tb/tb_mlp_patch_gather.sv
module tb_mlp_patch_gather;
   localparam int NP = 2, XYB = 9, TSB = 16, PB = 2, WS = 18;
   localparam int FW = 346, FH = 260;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 ev_vld = 1'b0, ev_rdy;
   logic [XYB-1:0]       ev_x = '0, ev_y = '0;
   logic [PB-1:0]        ev_pol = '0;
   logic [TSB-1:0]       ev_ts = '0;
   logic [NP-1:0]        mem_cen;
   logic                 mem_we;
   logic [NP*XYB-1:0]    mem_addr_x, mem_addr_y;
   logic [WS-1:0]        mem_wdata;
   logic [NP*WS-1:0]     mem_rdata = '0;
   logic                 feat_vld, feat_rdy = 1'b1, feat_last, busy, done;
   logic [NP-1:0]        feat_lane_vld;
   logic [NP*TSB-1:0]    feat_age;
   logic [NP*PB-1:0]     feat_pol;

   always #5 clk = ~clk;

   mlp_patch_gather dut (
      .clk_i(clk), .rst_i(rst),
      .ev_vld_i(ev_vld), .ev_rdy_o(ev_rdy), .ev_x_i(ev_x), .ev_y_i(ev_y),
      .ev_pol_i(ev_pol), .ev_ts_i(ev_ts),
      .mem_cen_o(mem_cen), .mem_we_o(mem_we), .mem_addr_x_o(mem_addr_x),
      .mem_addr_y_o(mem_addr_y), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .feat_vld_o(feat_vld), .feat_rdy_i(feat_rdy), .feat_lane_vld_o(feat_lane_vld),
      .feat_age_o(feat_age), .feat_pol_o(feat_pol), .feat_last_o(feat_last),
      .busy_o(busy), .done_o(done)
   );

   // Pixel memory model, one-cycle read latency
   logic [WS-1:0] mem [FW][FH];
   int mx, my;
   always @(posedge clk) begin
      for (int l = 0; l < NP; l++) begin
         if (mem_cen[l]) begin
            mx = int'(mem_addr_x[l*XYB +: XYB]);
            my = int'(mem_addr_y[l*XYB +: XYB]);
            if (mx < FW && my < FH) begin
               if (l == 0 && mem_we) mem[mx][my] = mem_wdata;
               else mem_rdata[l*WS +: WS] <= mem[mx][my];
            end
         end
      end
   end

   // Observation of popped beats and memory traffic
   logic [31:0] q_age[$];
   logic [3:0]  q_pol[$];
   logic [1:0]  q_lv[$];
   logic        q_last[$];
   int          q_cyc[$];
   int cyc = 0, issued = 0, popped = 0, cen_lanes = 0, oob = 0, dones = 0, wes = 0;
   logic [XYB-1:0] wx = '0, wy = '0;
   logic [WS-1:0]  wd = '0;
   always @(negedge clk) begin
      cyc++;
      if (feat_vld && feat_rdy) begin
         q_age.push_back(feat_age);
         q_pol.push_back(feat_pol);
         q_lv.push_back(feat_lane_vld);
         q_last.push_back(feat_last);
         q_cyc.push_back(cyc);
         popped++;
      end
      if (mem_cen != '0 && !mem_we) issued++;
      for (int l = 0; l < NP; l++) begin
         if (mem_cen[l] && !mem_we) begin
            cen_lanes++;
            if (int'(mem_addr_x[l*XYB +: XYB]) >= FW || int'(mem_addr_y[l*XYB +: XYB]) >= FH) oob++;
         end
      end
      if (done) dones++;
      if (mem_we) begin
         wes++;
         wx = mem_addr_x[XYB-1:0];
         wy = mem_addr_y[XYB-1:0];
         wd = mem_wdata;
      end
   end

   int vectors = 0, miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [WS-1:0] w(input int ts, input int pol);
      return {ts[TSB-1:0], pol[PB-1:0]};
   endfunction

   function automatic logic [15:0] age_at(input int idx, input int lane);
      logic [31:0] a;
      a = q_age[idx];
      return a[lane*TSB +: TSB];
   endfunction

   function automatic logic [1:0] pol_at(input int idx, input int lane);
      logic [3:0] p;
      p = q_pol[idx];
      return p[lane*PB +: PB];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, input int y, input int ts, input int pol);
      int n = 0;
      while (!ev_rdy && n < 200) begin
         tick();
         n++;
      end
      chk("ev_rdy_wait", ev_rdy, 1);
      ev_x = x[XYB-1:0];
      ev_y = y[XYB-1:0];
      ev_ts = ts[TSB-1:0];
      ev_pol = pol[PB-1:0];
      ev_vld = 1'b1;
      tick();
      ev_vld = 1'b0;
   endtask

   task automatic wait_evt(input int pop_target, input int done_target);
      int n = 0;
      while ((q_age.size() < pop_target || dones < done_target) && n < 400) begin
         tick();
         n++;
      end
      chk("beats_delivered", q_age.size(), pop_target);
      chk("done_pulses", dones, done_target);
   endtask

   initial begin
      int s, s2, d0, c0, o0, i0, p0, n, mx_out, out, errs, lvs, nz, lasts, k;
      foreach (mem[i, j]) mem[i][j] = '0;

      // Reset state
      #2;
      chk("rst_ev_rdy", ev_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cen", mem_cen, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_feat_vld", feat_vld, 0);
      chk("rst_done", done, 0);
      tick();
      rst = 1'b0;
      chk("rdy_before_edge", ev_rdy, 0);
      tick();
      chk("rdy_after_edge", ev_rdy, 1);

      // Centre event: latency, ages, padding lane, centre write
      mem[99][100] = w(990, 1);
      mem[101][100] = w(900, 1);
      mem[100][101] = w(999, 2);
      mem[99][99] = w(936, 1);
      s = q_age.size();
      d0 = dones;
      send(100, 100, 1000, 1);
      chk("busy_gather", busy, 1);
      chk("rdy_gather", ev_rdy, 0);
      chk("beat0_cen", mem_cen, 2'b11);
      chk("beat0_addr_x", mem_addr_x, {9'd98, 9'd97});
      chk("beat0_addr_y", mem_addr_y, {9'd97, 9'd97});
      tick();
      chk("lat_edge1", feat_vld, 0);
      tick();
      chk("lat_edge2", feat_vld, 0);
      tick();
      chk("lat_edge3", feat_vld, 1);
      wait_evt(s + 25, d0 + 1);
      chk("px99_100_age", age_at(s + 11, 1), 54);
      chk("px99_100_pol", pol_at(s + 11, 1), 1);
      chk("d100_age", age_at(s + 12, 1), 0);
      chk("d1_age", age_at(s + 15, 1), 63);
      chk("d1_pol", pol_at(s + 15, 1), 2);
      chk("d64_age", age_at(s + 8, 0), 0);
      chk("centre_old", age_at(s + 12, 0), 0);
      chk("last_beat_lv", q_lv[s + 24], 2'b01);
      chk("last_beat_flag", q_last[s + 24], 1);
      chk("beat23_not_last", q_last[s + 23], 0);
      chk("no_bubbles", q_cyc[s + 24] - q_cyc[s], 24);
      chk("wr_x", wx, 100);
      chk("wr_y", wy, 100);
      chk("wr_data", wd, w(1000, 1));
      chk("drained", feat_vld, 0);

      // Corner event: clipping
      mem[1][1] = w(1990, 3);
      s = q_age.size();
      d0 = dones;
      c0 = cen_lanes;
      o0 = oob;
      send(0, 0, 2000, 2);
      wait_evt(s + 25, d0 + 1);
      chk("corner_cen_lanes", cen_lanes - c0, 16);
      chk("corner_oob", oob - o0, 0);
      lvs = 0;
      nz = 0;
      for (int i = 0; i < 25; i++) begin
         lvs += $countones(q_lv[s + i]);
         for (int l = 0; l < NP; l++) if (age_at(s + i, l) != 0) nz++;
      end
      chk("corner_real_lanes", lvs, 49);
      chk("corner_nonzero", nz, 1);
      chk("corner_px11_age", age_at(s + 16, 0), 54);
      chk("corner_px11_pol", pol_at(s + 16, 0), 3);

      // Timestamp wrap
      mem[200][50] = w(65530, 1);
      s = q_age.size();
      d0 = dones;
      send(200, 50, 10, 1);
      wait_evt(s + 25, d0 + 1);
      chk("wrap_age", age_at(s + 12, 0), 48);

      // d=0 on a written word versus a never-written word
      mem[299][200] = w(0, 1);
      s = q_age.size();
      d0 = dones;
      send(300, 200, 0, 3);
      wait_evt(s + 25, d0 + 1);
      chk("d0_age", age_at(s + 11, 1), 64);
      chk("word0_age", age_at(s + 12, 1), 0);
      chk("word0_centre", age_at(s + 12, 0), 0);

      // Backpressure
      for (int kk = 0; kk < 49; kk++) mem[147 + kk % 7][147 + kk / 7] = w(3000 - kk, 1);
      s = q_age.size();
      d0 = dones;
      i0 = issued;
      p0 = popped;
      send(150, 150, 3000, 1);
      n = 0;
      while (q_age.size() < s + 5 && n < 100) begin
         tick();
         n++;
      end
      feat_rdy = 1'b0;
      mx_out = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         out = (issued - i0) - (popped - p0);
         if (out > mx_out) mx_out = out;
      end
      chk("stall_max_buffered", mx_out, 4);
      chk("stall_cen", mem_cen, 0);
      feat_rdy = 1'b1;
      wait_evt(s + 25, d0 + 1);
      errs = 0;
      for (int b = 0; b < 25; b++) begin
         for (int l = 0; l < NP; l++) begin
            k = 2 * b + l;
            if (age_at(s + b, l) != ((k < 49) ? 16'(64 - k) : 16'd0)) errs++;
            if (pol_at(s + b, l) != ((k < 49) ? 2'd1 : 2'd0)) errs++;
            if (q_lv[s + b][l] != (k < 49)) errs++;
         end
         if (q_last[s + b] != (b == 24)) errs++;
      end
      chk("stall_order", errs, 0);

      // Reset mid-gather
      d0 = dones;
      c0 = wes;
      i0 = issued;
      send(120, 120, 4000, 1);
      n = 0;
      while (issued < i0 + 10 && n < 100) begin
         tick();
         n++;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cen", mem_cen, 0);
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_feat_vld", feat_vld, 0);
      chk("mid_rst_rdy", ev_rdy, 0);
      chk("mid_rst_addr", mem_addr_x, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("post_rst_feat_vld", feat_vld, 0);
      chk("post_rst_no_write", wes - c0, 0);
      chk("post_rst_no_done", dones - d0, 0);
      s2 = q_age.size();
      send(120, 120, 4010, 1);
      wait_evt(s2 + 25, d0 + 1);
      lasts = 0;
      for (int i = 0; i < 25; i++) if (q_last[s2 + i]) lasts++;
      chk("post_rst_lasts", lasts, 1);
      chk("post_rst_last_pos", q_last[s2 + 24], 1);
      chk("post_rst_centre", age_at(s2 + 12, 0), 0);

      // Back-to-back events on the same pixel
      s = q_age.size();
      d0 = dones;
      send(60, 60, 500, 1);
      send(60, 60, 520, 2);
      wait_evt(s + 50, d0 + 2);
      chk("b2b_first_centre", age_at(s + 12, 0), 0);
      chk("b2b_first_last", q_last[s + 24], 1);
      chk("b2b_second_centre", age_at(s + 37, 0), 44);
      chk("b2b_second_pol", pol_at(s + 37, 0), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
